// File: rtl/axi4_if_pkg.sv
// axi4_if_pkg: error bit indices, AXI burst/resp encodings and size legality helper
package axi4_if_pkg;
  localparam int ERR_AW_HOLD = 0;
  localparam int ERR_W_HOLD  = 1;
  localparam int ERR_B_HOLD  = 2;
  localparam int ERR_AR_HOLD = 3;
  localparam int ERR_R_HOLD  = 4;
  localparam int ERR_AW_SIZE = 5;
  localparam int ERR_AR_SIZE = 6;
  localparam int ERR_KNOWN   = 7;
  localparam int ERR_B_UNDER = 8;
  localparam int ERR_R_UNDER = 9;
  localparam int ERR_W       = 10;
  typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP, BURST_RSVD} burst_e;
  typedef enum logic [1:0] {RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR} resp_e;
  function automatic logic size_bad(input logic [2:0] size, input int strb_w);
    return (1 << size) > strb_w;
  endfunction
endpackage

// File: rtl/axi4_if_if.sv
// axi4_if_if: AXI4 channel bundle with manager, subordinate and passive monitor views
interface axi4_if_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int USER_W = 1
);
  localparam int STRB_W = DATA_W / 8;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic [3:0]        awregion;
  logic [USER_W-1:0] awuser;
  logic              awvalid, awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic [USER_W-1:0] wuser;
  logic              wvalid, wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic [USER_W-1:0] buser;
  logic              bvalid, bready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic [3:0]        arregion;
  logic [USER_W-1:0] aruser;
  logic              arvalid, arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [USER_W-1:0] ruser;
  logic              rvalid, rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    output wdata, wstrb, wlast, wuser, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid, rready,
    input  awready, wready, bid, bresp, buser, bvalid, arready, rid, rdata, rresp, rlast, ruser, rvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    input  wdata, wstrb, wlast, wuser, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid, rready,
    output awready, wready, bid, bresp, buser, bvalid, arready, rid, rdata, rresp, rlast, ruser, rvalid
  );
  modport mon (
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    input wdata, wstrb, wlast, wuser, wvalid, bready,
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid, rready,
    input awready, wready, bid, bresp, buser, bvalid, arready, rid, rdata, rresp, rlast, ruser, rvalid
  );
endinterface

// File: rtl/axi4_if_hold_chk.sv
// axi4_if_hold_chk: flags a stalled channel that drops valid or changes payload before ready
module axi4_if_hold_chk #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic         ready,
  input  logic [W-1:0] payload,
  output logic         viol
);
  logic         hv, hr;
  logic [W-1:0] hp;
  // previous-cycle snapshot; cleared on reset so the first sampled cycle never checks
  always_ff @(posedge clk) begin
    if (rst) begin
      hv <= 1'b0;
      hr <= 1'b0;
      hp <= '0;
    end else begin
      hv <= valid;
      hr <= ready;
      hp <= payload;
    end
  end
  assign viol = hv && !hr && (!valid || payload != hp);
endmodule

// File: rtl/axi4_if.sv
// axi4_if: passive AXI4 monitor (handshakes, outstanding counts, sticky errors; X check under KVIPS_AXI4_IF_KNOWN_CHECK_EN)
module axi4_if
  import axi4_if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int USER_W = 1,
  parameter int OST_W  = 8
) (
  input  logic              aclk,
  input  logic              areset,
  axi4_if_if.mon            bus,
  input  logic              err_clr,
  output logic              aw_hs,
  output logic              w_hs,
  output logic              b_hs,
  output logic              ar_hs,
  output logic              r_hs,
  output logic [OST_W-1:0]  wr_ost,
  output logic [OST_W-1:0]  rd_ost,
  output logic [ERR_W-1:0]  err_flags,
  output logic              err_any
);
  localparam int STRB_W = DATA_W / 8;
  localparam int A_PW = ID_W + ADDR_W + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + USER_W;
  localparam int W_PW = DATA_W + STRB_W + 1 + USER_W;
  localparam int B_PW = ID_W + 2 + USER_W;
  localparam int R_PW = ID_W + DATA_W + 2 + 1 + USER_W;
  localparam logic [OST_W-1:0] OST_MAX = '1;
  logic [A_PW-1:0] aw_p, ar_p;
  logic [W_PW-1:0] w_p;
  logic [B_PW-1:0] b_p;
  logic [R_PW-1:0] r_p;
  logic aw_h, w_h, b_h, ar_h, r_h, rl_h;
  logic aw_v, w_v, b_v, ar_v, r_v, known_err, b_under, r_under;
  logic [OST_W-1:0] wr_nxt, rd_nxt;
  logic [ERR_W-1:0] err_new;
  assign aw_p = {bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awlock,
                 bus.awcache, bus.awprot, bus.awqos, bus.awregion, bus.awuser};
  assign ar_p = {bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arlock,
                 bus.arcache, bus.arprot, bus.arqos, bus.arregion, bus.aruser};
  assign w_p  = {bus.wdata, bus.wstrb, bus.wlast, bus.wuser};
  assign b_p  = {bus.bid, bus.bresp, bus.buser};
  assign r_p  = {bus.rid, bus.rdata, bus.rresp, bus.rlast, bus.ruser};
  assign aw_h = bus.awvalid && bus.awready;
  assign w_h  = bus.wvalid && bus.wready;
  assign b_h  = bus.bvalid && bus.bready;
  assign ar_h = bus.arvalid && bus.arready;
  assign r_h  = bus.rvalid && bus.rready;
  assign rl_h = r_h && bus.rlast;
  axi4_if_hold_chk #(.W(A_PW)) u_aw (.clk(aclk), .rst(areset), .valid(bus.awvalid), .ready(bus.awready), .payload(aw_p), .viol(aw_v));
  axi4_if_hold_chk #(.W(W_PW)) u_w  (.clk(aclk), .rst(areset), .valid(bus.wvalid),  .ready(bus.wready),  .payload(w_p),  .viol(w_v));
  axi4_if_hold_chk #(.W(B_PW)) u_b  (.clk(aclk), .rst(areset), .valid(bus.bvalid),  .ready(bus.bready),  .payload(b_p),  .viol(b_v));
  axi4_if_hold_chk #(.W(A_PW)) u_ar (.clk(aclk), .rst(areset), .valid(bus.arvalid), .ready(bus.arready), .payload(ar_p), .viol(ar_v));
  axi4_if_hold_chk #(.W(R_PW)) u_r  (.clk(aclk), .rst(areset), .valid(bus.rvalid),  .ready(bus.rready),  .payload(r_p),  .viol(r_v));
`ifdef KVIPS_AXI4_IF_KNOWN_CHECK_EN
  assign known_err = (bus.awvalid && $isunknown({bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst})) ||
                     (bus.wvalid  && $isunknown({bus.wdata, bus.wstrb, bus.wlast})) ||
                     (bus.arvalid && $isunknown({bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst})) ||
                     (bus.rvalid  && $isunknown({bus.rid, bus.rdata, bus.rlast, bus.rresp})) ||
                     (bus.bvalid  && $isunknown({bus.bid, bus.bresp}));
`else
  assign known_err = 1'b0;
`endif
  assign b_under = b_h && !aw_h && wr_ost == '0;
  assign r_under = rl_h && !ar_h && rd_ost == '0;
  assign err_new = {r_under, b_under, known_err,
                    bus.arvalid && size_bad(bus.arsize, STRB_W),
                    bus.awvalid && size_bad(bus.awsize, STRB_W),
                    r_v, ar_v, b_v, w_v, aw_v};
  // saturating up/down counts; simultaneous inc and dec cancel, underflow holds at zero
  always_comb begin
    wr_nxt = (aw_h && !b_h) ? (wr_ost == OST_MAX ? wr_ost : wr_ost + 1'b1) :
             (b_h && !aw_h && wr_ost != '0) ? wr_ost - 1'b1 : wr_ost;
    rd_nxt = (ar_h && !rl_h) ? (rd_ost == OST_MAX ? rd_ost : rd_ost + 1'b1) :
             (rl_h && !ar_h && rd_ost != '0) ? rd_ost - 1'b1 : rd_ost;
  end
  // registered outputs; a fresh violation beats a same-cycle clear
  always_ff @(posedge aclk) begin
    if (areset) begin
      {aw_hs, w_hs, b_hs, ar_hs, r_hs} <= '0;
      wr_ost    <= '0;
      rd_ost    <= '0;
      err_flags <= '0;
    end else begin
      {aw_hs, w_hs, b_hs, ar_hs, r_hs} <= {aw_h, w_h, b_h, ar_h, r_h};
      wr_ost    <= wr_nxt;
      rd_ost    <= rd_nxt;
      err_flags <= (err_clr ? '0 : err_flags) | err_new;
    end
  end
  assign err_any = |err_flags;
endmodule

// File: tb/tb_axi4_if.sv
// tb_axi4_if: table-driven and directed checks of the axi4_if monitor
module tb_axi4_if;
  logic aclk = 1'b0, areset = 1'b1, err_clr = 1'b0;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, err_any;
  logic [7:0] wr_ost, rd_ost;
  logic [9:0] err_flags;
  int n_chk = 0, n_fail = 0;
  axi4_if_if bus ();
  axi4_if dut (
    .aclk(aclk), .areset(areset), .bus(bus), .err_clr(err_clr),
    .aw_hs(aw_hs), .w_hs(w_hs), .b_hs(b_hs), .ar_hs(ar_hs), .r_hs(r_hs),
    .wr_ost(wr_ost), .rd_ost(rd_ost), .err_flags(err_flags), .err_any(err_any)
  );
  always #5 aclk = ~aclk;
  typedef struct {
    logic [4:0] hs_in;
    logic       rlast;
    logic [2:0] awsize;
    logic [2:0] arsize;
    logic [4:0] hs;
    logic [7:0] wr;
    logic [7:0] rd;
    logic [9:0] err;
  } vec_t;
  vec_t vt [10];
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic idle();
    err_clr = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awlock = '0;
    bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awregion = '0; bus.awuser = '0;
    bus.awvalid = 1'b0; bus.awready = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wuser = '0; bus.wvalid = 1'b0; bus.wready = 1'b0;
    bus.bid = '0; bus.bresp = '0; bus.buser = '0; bus.bvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arlock = '0;
    bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arregion = '0; bus.aruser = '0;
    bus.arvalid = 1'b0; bus.arready = 1'b0;
    bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0; bus.ruser = '0;
    bus.rvalid = 1'b0; bus.rready = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_hs"}, {27'd0, r_hs, ar_hs, b_hs, w_hs, aw_hs}, 32'd0);
    chk({tag, "_wr"}, {24'd0, wr_ost}, 32'd0);
    chk({tag, "_rd"}, {24'd0, rd_ost}, 32'd0);
    chk({tag, "_err"}, {21'd0, err_any, err_flags}, 32'd0);
  endtask
  task automatic do_reset();
    idle();
    areset = 1'b1;
    tick();
    areset = 1'b0;
  endtask
  initial begin
    vt[0] = '{5'b00001, 1'b0, 3'd3, 3'd3, 5'b00001, 8'd1, 8'd0, 10'h000};
    vt[1] = '{5'b00011, 1'b0, 3'd3, 3'd3, 5'b00011, 8'd2, 8'd0, 10'h000};
    vt[2] = '{5'b00100, 1'b0, 3'd3, 3'd3, 5'b00100, 8'd1, 8'd0, 10'h000};
    vt[3] = '{5'b01000, 1'b0, 3'd3, 3'd3, 5'b01000, 8'd1, 8'd1, 10'h000};
    vt[4] = '{5'b10000, 1'b0, 3'd3, 3'd3, 5'b10000, 8'd1, 8'd1, 10'h000};
    vt[5] = '{5'b10100, 1'b1, 3'd3, 3'd3, 5'b10100, 8'd0, 8'd0, 10'h000};
    vt[6] = '{5'b00101, 1'b0, 3'd3, 3'd3, 5'b00101, 8'd0, 8'd0, 10'h000};
    vt[7] = '{5'b11000, 1'b1, 3'd3, 3'd3, 5'b11000, 8'd0, 8'd0, 10'h000};
    vt[8] = '{5'b00000, 1'b0, 3'd3, 3'd3, 5'b00000, 8'd0, 8'd0, 10'h000};
    vt[9] = '{5'b00001, 1'b0, 3'd4, 3'd3, 5'b00001, 8'd1, 8'd0, 10'h020};
    idle();
    tick();
    tick();
    chk_zero("in_reset");
    areset = 1'b0;
    tick();
    chk_zero("post_release");
    for (int i = 0; i < 10; i++) begin
      {bus.rvalid, bus.arvalid, bus.bvalid, bus.wvalid, bus.awvalid} = vt[i].hs_in;
      {bus.rready, bus.arready, bus.bready, bus.wready, bus.awready} = vt[i].hs_in;
      bus.rlast = vt[i].rlast;
      bus.awsize = vt[i].awsize;
      bus.arsize = vt[i].arsize;
      tick();
      chk($sformatf("vec%0d_hs", i), {27'd0, r_hs, ar_hs, b_hs, w_hs, aw_hs}, {27'd0, vt[i].hs});
      chk($sformatf("vec%0d_wr", i), {24'd0, wr_ost}, {24'd0, vt[i].wr});
      chk($sformatf("vec%0d_rd", i), {24'd0, rd_ost}, {24'd0, vt[i].rd});
      chk($sformatf("vec%0d_err", i), {22'd0, err_flags}, {22'd0, vt[i].err});
    end
    idle();
    err_clr = 1'b1;
    tick();
    chk("clr_err", {21'd0, err_any, err_flags}, 32'd0);
    chk("clr_keeps_wr", {24'd0, wr_ost}, 32'd1);
    idle();
    bus.awvalid = 1'b1;
    bus.awaddr = 32'h100;
    tick();
    chk("stall_first", {22'd0, err_flags}, 32'd0);
    bus.awaddr = 32'h104;
    tick();
    chk("aw_hold_err", {22'd0, err_flags}, 32'h001);
    chk("aw_hold_any", {31'd0, err_any}, 32'd1);
    bus.awvalid = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    chk("aw_hold_clr", {21'd0, err_any, err_flags}, 32'd0);
    err_clr = 1'b0;
    bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    err_clr = 1'b1;
    tick();
    chk("viol_beats_clr", {22'd0, err_flags}, 32'h001);
    tick();
    chk("clr_again", {22'd0, err_flags}, 32'd0);
    idle();
    bus.arvalid = 1'b1; bus.arready = 1'b1; bus.arsize = 3'd4;
    tick();
    chk("ar_size4", {22'd0, err_flags}, 32'h040);
    idle();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    bus.arvalid = 1'b1; bus.arready = 1'b1; bus.arsize = 3'd3;
    tick();
    chk("ar_size3", {22'd0, err_flags}, 32'd0);
    do_reset();
    tick();
    chk_zero("reset2");
    bus.awvalid = 1'b1; bus.awready = 1'b1;
    tick();
    chk("aw1_hs", {31'd0, aw_hs}, 32'd1);
    chk("aw1_wr", {24'd0, wr_ost}, 32'd1);
    tick();
    chk("aw2_wr", {24'd0, wr_ost}, 32'd2);
    idle();
    tick();
    chk("aw_pulse_end", {31'd0, aw_hs}, 32'd0);
    bus.bvalid = 1'b1; bus.bready = 1'b1;
    tick();
    chk("b_hs", {31'd0, b_hs}, 32'd1);
    chk("b_wr", {24'd0, wr_ost}, 32'd1);
    idle();
    tick();
    chk("b_pulse_end", {31'd0, b_hs}, 32'd0);
    do_reset();
    bus.arvalid = 1'b1; bus.arready = 1'b1; bus.arlen = 8'd3;
    tick();
    chk("rd_ar_hs", {31'd0, ar_hs}, 32'd1);
    chk("rd_ost_1", {24'd0, rd_ost}, 32'd1);
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = (i == 3); bus.rdata = 64'(i);
      tick();
      chk($sformatf("beat%0d_rhs", i), {31'd0, r_hs}, 32'd1);
      chk($sformatf("beat%0d_rd", i), {24'd0, rd_ost}, (i == 3) ? 32'd0 : 32'd1);
    end
    idle();
    tick();
    chk("r_pulse_end", {31'd0, r_hs}, 32'd0);
    chk("r_no_err", {22'd0, err_flags}, 32'd0);
    do_reset();
    bus.bvalid = 1'b1; bus.bready = 1'b1;
    tick();
    chk("b_under_err", {22'd0, err_flags}, 32'h100);
    chk("b_under_wr", {24'd0, wr_ost}, 32'd0);
    do_reset();
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
    tick();
    chk("r_under_err", {22'd0, err_flags}, 32'h200);
    chk("r_under_rd", {24'd0, rd_ost}, 32'd0);
    do_reset();
    bus.wvalid = 1'b1; bus.wready = 1'b1; bus.wdata = 'x;
    tick();
`ifdef KVIPS_AXI4_IF_KNOWN_CHECK_EN
    chk("known_w", {31'd0, err_flags[7]}, 32'd1);
`else
    chk("known_w", {31'd0, err_flags[7]}, 32'd0);
`endif
    do_reset();
    bus.awvalid = 1'b1; bus.awready = 1'b1;
    for (int i = 0; i < 256; i++) tick();
    chk("sat_wr", {24'd0, wr_ost}, 32'd255);
    chk("sat_no_err", {22'd0, err_flags}, 32'd0);
    idle();
    bus.bvalid = 1'b1; bus.bready = 1'b1;
    tick();
    chk("sat_dec", {24'd0, wr_ost}, 32'd254);
    bus.awvalid = 1'b1; bus.awready = 1'b0;
    tick();
    bus.awvalid = 1'b0;
    tick();
    chk("pre_reset_err", {22'd0, err_flags}, 32'h001);
    bus.awvalid = 1'b1; bus.awready = 1'b1;
    areset = 1'b1;
    tick();
    chk_zero("mid_reset");
    idle();
    areset = 1'b0;
    tick();
    chk_zero("after_mid_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
